lector_destinos: RTL and testbench
==================================

Name: lector_destinos

Overview:
- Consumer end of the transaction layer's destination FIFOs D0/D1.
- Watches D0_can_pop and D1_can_pop and issues pop_D0/pop_D1, at most one pop per cycle, using round-robin arbitration.
- Captures each popped word and presents it on a single output stream tagged with its source destination.
- Keeps per-destination and total word counters, readable through a req/idx port, so the bench can compare counts against words pushed.

Parameters:
BITNUMBER, 8, word width of the D0/D1 FIFOs and of data_out
CNT_WIDTH, 5, width of every word counter and of count_out

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
init  input  1  synchronous clear of counters/arbiter; acts as a one-cycle restart
D0_can_pop  input  1  D0 FIFO non-empty
D1_can_pop  input  1  D1 FIFO non-empty
D0_data_in  input  BITNUMBER  D0 head word (show-ahead; valid while D0_can_pop=1)
D1_data_in  input  BITNUMBER  D1 head word (show-ahead)
pop_D0  output  1  combinational pop strobe to D0
pop_D1  output  1  combinational pop strobe to D1
data_out  output  BITNUMBER  registered captured word
dest_out  output  1  source of data_out: 0 = D0, 1 = D1
valid_out  output  1  data_out/dest_out valid for exactly this cycle
req  input  1  counter read request
idx  input  2  0 = D0 count, 1 = D1 count, 2 = total, 3 = reserved (reads 0)
count_out  output  CNT_WIDTH  registered counter value
count_valid  output  1  count_out valid for exactly this cycle
idle  output  1  FSM in IDLE
err  output  1  destination mismatch flag (optional feature only)

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - FSM state to INIT; round-robin pointer to D0; all counters to 0.
  - data_out, dest_out, valid_out, count_out, count_valid, idle and err to 0.
  - pop_D0 and pop_D1 to 0.
- FSM states:
  - INIT: pops blocked; counters and round-robin pointer cleared. Lasts one cycle, then goes to IDLE.
  - IDLE: idle=1. Moves to ACTIVE on the next edge if D0_can_pop or D1_can_pop is 1.
  - ACTIVE: popping. Moves to IDLE when both can_pop inputs are 0.
  - init=1 in any state: next state is INIT, and pops in that same cycle are suppressed.
- Pop policy (ACTIVE only; combinational from state, can_pop inputs and pointer):
  - Only one can_pop is 1: pop that FIFO.
  - Both are 1: pop the FIFO the pointer selects, then flip the pointer to the other FIFO.
  - The pointer changes only on a contested cycle.
  - pop_D0 and pop_D1 are never 1 together.
  - pop_Dx is never 1 while Dx_can_pop=0.
- Capture (latency 1):
  - Trigger: the edge that ends a cycle with pop_Dx=1.
  - At that edge: data_out <= Dx_data_in; dest_out <= x; valid_out <= 1 for the following cycle.
  - Otherwise valid_out=0. data_out and dest_out hold their last values.
- Counters:
  - cnt_D0, cnt_D1 and cnt_T are each CNT_WIDTH bits.
  - Each increments on the same edge as the capture; cnt_T increments on every pop.
  - All counters wrap from 2^CNT_WIDTH-1 to 0.
- Readout:
  - req=1 at edge N loads count_out with the selected counter's pre-increment value at edge N.
  - count_valid=1 in the following cycle. Readout works in every state.
  - req during init returns the pre-clear value.
  - idx=3 returns 0 with count_valid=1.

Optional Feature:
Macro DEST_CHECK_EN.
- Defined:
  - Bit 4 of a popped word is its destination tag; requires BITNUMBER >= 5.
  - Each capture compares bit 4 of the word with the source FIFO.
  - A mismatch sets err on the same edge as the capture.
  - err is sticky and is cleared only by reset or init.
- Not defined: err is tied to 0 and no compare logic is built.

Test Plan:
- Reset released, init pulsed 1 cycle, both can_pop=0 -> idle=1 two cycles later; pop_D0, pop_D1 and valid_out stay 0.
- D0_can_pop=1 for 3 cycles, D0_data_in = 0x05, 0x0A, 0x0F:
  - pop_D0 is high 3 cycles.
  - data_out shows 0x05, 0x0A, 0x0F with dest_out=0 and valid_out=1, each one cycle after its pop.
  - req with idx=0 then returns 3.
- Both can_pop=1 for 4 cycles after reset -> pops alternate D0, D1, D0, D1; req with idx=2 then returns 4.
- 33 pops from D1 with CNT_WIDTH=5 -> idx=1 reads 1 (wrapped); idx=3 reads 0 with count_valid=1.
- init=1 while ACTIVE with both can_pop=1:
  - No pop in the init cycle; the following INIT cycle is also blocked.
  - All counters read 0 afterwards; popping resumes at D0.
- With DEST_CHECK_EN: pop a D1 word 0x03 (bit4=0) -> err=1 from the next cycle until init; pop a D1 word 0x13 -> err stays 0.

Source files
------------

// File: rtl/lector_destinos_if.sv
// Destination-FIFO read bus for lector_destinos.
// Groups the D0/D1 pop handshake, the tagged output stream and the counter readout port.
interface lector_destinos_if #(
  parameter int BITNUMBER = 8,
  parameter int CNT_WIDTH = 5
);
  logic                 D0_can_pop;
  logic                 D1_can_pop;
  logic [BITNUMBER-1:0] D0_data_in;
  logic [BITNUMBER-1:0] D1_data_in;
  logic                 pop_D0;
  logic                 pop_D1;
  logic [BITNUMBER-1:0] data_out;
  logic                 dest_out;
  logic                 valid_out;
  logic                 req;
  logic [1:0]           idx;
  logic [CNT_WIDTH-1:0] count_out;
  logic                 count_valid;

  // master: the reader (lector_destinos); slave: the FIFOs and the consumer of the stream
  modport master (
    input  D0_can_pop, D1_can_pop, D0_data_in, D1_data_in, req, idx,
    output pop_D0, pop_D1, data_out, dest_out, valid_out, count_out, count_valid
  );

  modport slave (
    output D0_can_pop, D1_can_pop, D0_data_in, D1_data_in, req, idx,
    input  pop_D0, pop_D1, data_out, dest_out, valid_out, count_out, count_valid
  );
endinterface

// File: rtl/lector_destinos.sv
// Round-robin reader of destination FIFOs D0/D1 with tagged output stream and word counters.
// Optional macro DEST_CHECK_EN: checks bit 4 of each popped word against its source FIFO (sticky err).
module lector_destinos #(
  parameter int BITNUMBER = 8,
  parameter int CNT_WIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  lector_destinos_if.master bus,
  output logic              idle,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               state;
  logic                 rr_ptr;
  logic [CNT_WIDTH-1:0] cnt_d0;
  logic [CNT_WIDTH-1:0] cnt_d1;
  logic [CNT_WIDTH-1:0] cnt_t;

  logic                 any_pending;
  logic                 pop_ok;
  logic                 contested;
  logic                 pop_d0;
  logic                 pop_d1;
  logic                 pop_any;
  logic [BITNUMBER-1:0] word_p0;

  logic [BITNUMBER-1:0] data_p1;
  logic                 dest_p1;
  logic                 vld_p1;
  logic [CNT_WIDTH-1:0] count_p1;
  logic                 count_vld_p1;

  function automatic logic [CNT_WIDTH-1:0] wrap_inc(input logic [CNT_WIDTH-1:0] v);
    return v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] select_count(
    input logic [1:0]           sel,
    input logic [CNT_WIDTH-1:0] c0,
    input logic [CNT_WIDTH-1:0] c1,
    input logic [CNT_WIDTH-1:0] ct
  );
    logic [CNT_WIDTH-1:0] r;
    case (sel)
      2'd0:    r = c0;
      2'd1:    r = c1;
      2'd2:    r = ct;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational arbitration; init suppresses pops in its own cycle
  assign any_pending = bus.D0_can_pop | bus.D1_can_pop;
  assign pop_ok      = (state == ST_ACTIVE) && !init;
  assign contested   = pop_ok && bus.D0_can_pop && bus.D1_can_pop;
  assign pop_d0      = pop_ok && bus.D0_can_pop && (!bus.D1_can_pop || !rr_ptr);
  assign pop_d1      = pop_ok && bus.D1_can_pop && (!bus.D0_can_pop ||  rr_ptr);
  assign pop_any     = pop_d0 | pop_d1;
  assign word_p0     = pop_d1 ? bus.D1_data_in : bus.D0_data_in;

  assign bus.pop_D0  = pop_d0;
  assign bus.pop_D1  = pop_d1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
      idle  <= 1'b0;
    end else if (init) begin
      state <= ST_INIT;
      idle  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
        ST_IDLE: begin
          if (any_pending) begin
            state <= ST_ACTIVE;
            idle  <= 1'b0;
          end else begin
            idle  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!any_pending) begin
            state <= ST_IDLE;
            idle  <= 1'b1;
          end else begin
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          idle  <= 1'b0;
        end
      endcase
    end
  end

  // Pointer flips only when both FIFOs competed; counters clear on init and throughout INIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
      cnt_d0 <= '0;
      cnt_d1 <= '0;
      cnt_t  <= '0;
    end else if (init || (state == ST_INIT)) begin
      rr_ptr <= 1'b0;
      cnt_d0 <= '0;
      cnt_d1 <= '0;
      cnt_t  <= '0;
    end else begin
      if (contested) rr_ptr <= ~rr_ptr;
      if (pop_d0)    cnt_d0 <= wrap_inc(cnt_d0);
      if (pop_d1)    cnt_d1 <= wrap_inc(cnt_d1);
      if (pop_any)   cnt_t  <= wrap_inc(cnt_t);
    end
  end

  // Stage p1: captured word and counter readout, valid for exactly one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p1      <= '0;
      dest_p1      <= 1'b0;
      vld_p1       <= 1'b0;
      count_p1     <= '0;
      count_vld_p1 <= 1'b0;
    end else begin
      vld_p1       <= pop_any;
      count_vld_p1 <= bus.req;
      if (pop_any) begin
        data_p1 <= word_p0;
        dest_p1 <= pop_d1;
      end
      if (bus.req) count_p1 <= select_count(bus.idx, cnt_d0, cnt_d1, cnt_t);
    end
  end

  assign bus.data_out    = data_p1;
  assign bus.dest_out    = dest_p1;
  assign bus.valid_out   = vld_p1;
  assign bus.count_out   = count_p1;
  assign bus.count_valid = count_vld_p1;

`ifdef DEST_CHECK_EN
  function automatic logic tag_mismatch(input logic [BITNUMBER-1:0] w, input logic src);
    return w[4] != src;
  endfunction

  logic err_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_p1 <= 1'b0;
    end else if (init) begin
      err_p1 <= 1'b0;
    end else if (pop_any && tag_mismatch(word_p0, pop_d1)) begin
      err_p1 <= 1'b1;
    end
  end

  assign err = err_p1;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lector_destinos.sv
// Directed self-checking bench for lector_destinos: reset, single-FIFO stream, round robin,
// counter wrap, init restart and destination-tag check.
module tb_lector_destinos;

  logic clk;
  logic reset;
  logic init;
  logic idle;
  logic err;
  int   checks;
  int   errors;
  int   n;
  logic [7:0] words [3];

`ifdef DEST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  lector_destinos_if #(.BITNUMBER(8), .CNT_WIDTH(5)) bus ();

  lector_destinos #(.BITNUMBER(8), .CNT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .bus   (bus),
    .idle  (idle),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    init  = 1'b0;
    bus.D0_can_pop = 1'b0;
    bus.D1_can_pop = 1'b0;
    bus.D0_data_in = 8'h00;
    bus.D1_data_in = 8'h00;
    bus.req = 1'b0;
    bus.idx = 2'd0;
    words = '{8'h05, 8'h0A, 8'h0F};

    // asynchronous reset state
    #1 reset = 1'b0;
    #1;
    check("rst_data",   bus.data_out, 0);
    check("rst_dest",   bus.dest_out, 0);
    check("rst_valid",  bus.valid_out, 0);
    check("rst_count",  bus.count_out, 0);
    check("rst_cvalid", bus.count_valid, 0);
    check("rst_idle",   idle, 0);
    check("rst_err",    err, 0);
    check("rst_pop0",   bus.pop_D0, 0);
    check("rst_pop1",   bus.pop_D1, 0);
    tick();
    tick();
    reset = 1'b1;

    // init pulse with nothing to pop
    init = 1'b1;
    tick();
    init = 1'b0;
    check("t1_idle_in_init", idle, 0);
    check("t1_pop0_init", bus.pop_D0, 0);
    tick();
    check("t1_idle", idle, 1);
    check("t1_pop0", bus.pop_D0, 0);
    check("t1_pop1", bus.pop_D1, 0);
    check("t1_valid", bus.valid_out, 0);

    // D0 only, three words
    bus.D0_can_pop = 1'b1;
    bus.D0_data_in = words[0];
    settle();
    check("t2_nopop_idle", bus.pop_D0, 0);
    tick();
    check("t2_active_idle", idle, 0);
    for (int i = 0; i < 3; i++) begin
      check("t2_pop0", bus.pop_D0, 1);
      check("t2_pop1", bus.pop_D1, 0);
      tick();
      check("t2_data", bus.data_out, words[i]);
      check("t2_dest", bus.dest_out, 0);
      check("t2_valid", bus.valid_out, 1);
      if (i < 2) bus.D0_data_in = words[i+1];
      else       bus.D0_can_pop = 1'b0;
      settle();
    end
    check("t2_pop0_after", bus.pop_D0, 0);
    bus.req = 1'b1;
    bus.idx = 2'd0;
    tick();
    bus.req = 1'b0;
    check("t2_valid_end", bus.valid_out, 0);
    check("t2_cnt_d0", bus.count_out, 3);
    check("t2_cvalid", bus.count_valid, 1);
    check("t2_idle_back", idle, 1);
    tick();
    check("t2_cvalid_drop", bus.count_valid, 0);

    // reset, then both FIFOs contend for four cycles
    reset = 1'b0;
    settle();
    reset = 1'b1;
    check("t3_rst_data", bus.data_out, 0);
    bus.D0_can_pop = 1'b1;
    bus.D1_can_pop = 1'b1;
    bus.D0_data_in = 8'hA0;
    bus.D1_data_in = 8'hB1;
    settle();
    check("t3_init_block", bus.pop_D0 | bus.pop_D1, 0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t3_pop0", bus.pop_D0, (i % 2 == 0) ? 1 : 0);
      check("t3_pop1", bus.pop_D1, (i % 2 == 1) ? 1 : 0);
      tick();
      check("t3_dest", bus.dest_out, (i % 2 == 1) ? 1 : 0);
      check("t3_data", bus.data_out, (i % 2 == 1) ? 32'hB1 : 32'hA0);
      check("t3_valid", bus.valid_out, 1);
      if (i == 3) begin
        bus.D0_can_pop = 1'b0;
        bus.D1_can_pop = 1'b0;
        bus.req = 1'b1;
        bus.idx = 2'd2;
      end
      settle();
    end
    check("t3_nopop", bus.pop_D0 | bus.pop_D1, 0);
    tick();
    check("t3_cnt_total", bus.count_out, 4);
    check("t3_cvalid", bus.count_valid, 1);
    bus.idx = 2'd0;
    tick();
    bus.req = 1'b0;
    check("t3_cnt_d0", bus.count_out, 2);

    // 33 pops from D1: counter wraps to 1
    reset = 1'b0;
    settle();
    reset = 1'b1;
    bus.D1_can_pop = 1'b1;
    bus.D1_data_in = 8'h10;
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 33; i++) begin
      bus.D1_data_in = 8'h10 | 8'(i % 16);
      settle();
      if (bus.pop_D1 === 1'b1) n++;
      tick();
    end
    bus.D1_can_pop = 1'b0;
    bus.req = 1'b1;
    bus.idx = 2'd1;
    check("t4_npops", n, 33);
    check("t4_last_data", bus.data_out, 8'h10);
    check("t4_last_dest", bus.dest_out, 1);
    tick();
    check("t4_cnt_d1_wrap", bus.count_out, 1);
    check("t4_cvalid", bus.count_valid, 1);
    bus.idx = 2'd3;
    tick();
    check("t4_idx3", bus.count_out, 0);
    check("t4_idx3_valid", bus.count_valid, 1);
    bus.idx = 2'd2;
    tick();
    bus.req = 1'b0;
    check("t4_cnt_total_wrap", bus.count_out, 1);

    // init while ACTIVE with both FIFOs non-empty
    bus.D0_can_pop = 1'b1;
    bus.D1_can_pop = 1'b1;
    bus.D0_data_in = 8'h21;
    bus.D1_data_in = 8'h32;
    tick();
    check("t5_pop0_first", bus.pop_D0, 1);
    check("t5_pop1_first", bus.pop_D1, 0);
    tick();
    check("t5_data0", bus.data_out, 8'h21);
    check("t5_pop1_second", bus.pop_D1, 1);
    tick();
    check("t5_data1", bus.data_out, 8'h32);
    check("t5_dest1", bus.dest_out, 1);
    check("t5_pop0_pre_init", bus.pop_D0, 1);
    init = 1'b1;
    bus.req = 1'b1;
    bus.idx = 2'd2;
    settle();
    check("t5_init_pop0", bus.pop_D0, 0);
    check("t5_init_pop1", bus.pop_D1, 0);
    tick();
    init = 1'b0;
    bus.req = 1'b0;
    check("t5_preclear_total", bus.count_out, 3);
    check("t5_valid_init", bus.valid_out, 0);
    check("t5_initstate_block", bus.pop_D0 | bus.pop_D1, 0);
    tick();
    check("t5_idle_block", bus.pop_D0 | bus.pop_D1, 0);
    check("t5_idle", idle, 1);
    check("t5_valid_idle", bus.valid_out, 0);
    tick();
    check("t5_resume_pop0", bus.pop_D0, 1);
    check("t5_resume_pop1", bus.pop_D1, 0);
    bus.req = 1'b1;
    bus.idx = 2'd2;
    tick();
    check("t5_total_cleared", bus.count_out, 0);
    check("t5_resume_data", bus.data_out, 8'h21);
    check("t5_resume_dest", bus.dest_out, 0);
    bus.D0_can_pop = 1'b0;
    bus.D1_can_pop = 1'b0;
    bus.idx = 2'd1;
    tick();
    bus.req = 1'b0;
    check("t5_d1_cleared", bus.count_out, 0);

    // destination tag check on D1 words
    bus.D1_can_pop = 1'b1;
    bus.D1_data_in = 8'h13;
    tick();
    tick();
    check("t6_data13", bus.data_out, 8'h13);
    check("t6_err_ok", err, 0);
    bus.D1_data_in = 8'h03;
    tick();
    bus.D1_can_pop = 1'b0;
    check("t6_data03", bus.data_out, 8'h03);
    check("t6_err_set", err, EXP_ERR);
    tick();
    check("t6_err_sticky", err, EXP_ERR);
    init = 1'b1;
    tick();
    init = 1'b0;
    check("t6_err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
